// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (FETCH, WAIT, HOLD, DROP)
//   PC_STEP       : PC increment between sequential instructions
//   RS/RT/RD_*    : register-specifier bit-field positions in an instruction
//   pc_align      : clears the byte-offset bits of an address
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;

   function automatic logic [31:0] pc_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time to instruction
// memory and delivers the returned words into an IF/ID slot, with a
// one-entry skid register so a response arriving under stall is not lost.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req / imem_addr     : read request and byte address (= pc)
//   imem_gnt                 : request accepted this cycle
//   imem_rvalid / imem_rdata : read response
//   stall                    : decode cannot accept, IF/ID slot holds
//   redirect / redirect_pc   : taken branch/jump, flush and refetch
//   if_valid/if_instr/if_pc  : IF/ID slot
//   rs, rt, rd               : register specifiers decoded from if_instr
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  skid_instr;
   logic [31:0]  skid_pc;

   // The request is a pure function of the registered state; rst gates it so
   // nothing is requested while the memory is itself being reset.
   assign imem_req  = (state == FETCH) && !rst;
   assign imem_addr = pc;

   assign rs = if_instr[RS_MSB:RS_LSB];
   assign rt = if_instr[RT_MSB:RT_LSB];
   assign rd = if_instr[RD_MSB:RD_LSB];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= pc_align(RESET_PC);
         if_valid   <= 1'b0;
         if_instr   <= 32'h0;
         if_pc      <= 32'h0;
         skid_instr <= 32'h0;
         skid_pc    <= 32'h0;
      end else if (redirect) begin
         // Flush overrides stall. Leaving HOLD empties the skid entry; an
         // in-flight request whose data has not yet arrived is dropped.
         pc       <= pc_align(redirect_pc);
         if_valid <= 1'b0;
         case (state)
            FETCH:   state <= imem_gnt    ? DROP  : FETCH;
            WAIT:    state <= imem_rvalid ? FETCH : DROP;
            HOLD:    state <= FETCH;
            DROP:    state <= imem_rvalid ? FETCH : DROP;
            default: state <= FETCH;
         endcase
      end else begin
         // Consumed instruction leaves the slot unless something loads below.
         if (if_valid && !stall) begin
            if_valid <= 1'b0;
         end
         case (state)
            FETCH: begin
               if (imem_gnt) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (!if_valid || !stall) begin
                     if_valid <= 1'b1;
                     if_instr <= imem_rdata;
                     if_pc    <= pc;
                     state    <= FETCH;
                  end else begin
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc;
                     state      <= HOLD;
                  end
                  pc <= pc + PC_STEP;
               end
            end
            HOLD: begin
               // No new request until the skid entry has moved into the slot.
               if (!stall) begin
                  if_valid <= 1'b1;
                  if_instr <= skid_instr;
                  if_pc    <= skid_pc;
                  state    <= FETCH;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model (a queue of delivered
// instructions plus an outstanding-request flag) and a latency-programmable
// instruction memory.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .rs(rs), .rt(rt), .rd(rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } slot_t;

   // Reference model: instructions delivered but not yet consumed, in order.
   slot_t       q[$];
   bit          m_out   = 1'b0;   // a granted request awaits its response
   bit          m_drop  = 1'b0;   // that response is to be discarded
   bit          m_clean = 1'b1;   // slot registers still hold reset values
   logic [31:0] m_pc    = RESET_PC;

   // Memory model.
   bit          mem_pend = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr = 32'h0;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0) return 32'h012A_4020;
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance model and memory across the posedge. l = response latency for a
   // request granted in this cycle.
   task automatic step(input bit r, input bit st, input bit g, input bit rdr,
                       input logic [31:0] rpc, input int l);
      bit    rv;
      bit    er;
      slot_t h;
      slot_t n;
      rst = r; stall = st; imem_gnt = g; redirect = rdr; redirect_pc = rpc;
      rv = mem_pend && (mem_cnt == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? word_at(mem_addr) : $urandom;
      #1;
      er = !r && !m_out && (q.size() < 2);
      chk("imem_req", {31'h0, imem_req}, {31'h0, er});
      if (er) chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", {31'h0, if_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
         h = q[0];
         chk("if_instr", if_instr, h.instr);
         chk("if_pc", if_pc, h.pc);
         chk("rs", {27'h0, rs}, {27'h0, h.instr[25:21]});
         chk("rt", {27'h0, rt}, {27'h0, h.instr[20:16]});
         chk("rd", {27'h0, rd}, {27'h0, h.instr[15:11]});
      end else if (m_clean) begin
         chk("if_instr_rst", if_instr, 32'h0);
         chk("if_pc_rst", if_pc, 32'h0);
         chk("rs_rt_rd_rst", {17'h0, rs, rt, rd}, 32'h0);
      end
      if (r) begin
         q.delete(); m_out = 0; m_drop = 0; m_pc = RESET_PC; m_clean = 1;
      end else if (rdr) begin
         q.delete();
         m_pc = rpc & ~32'h3;
         if (m_out) begin
            if (rv) begin m_out = 0; m_drop = 0; end
            else m_drop = 1;
         end
         if (er && g) begin m_out = 1; m_drop = 1; end
      end else begin
         if (q.size() != 0 && !st) void'(q.pop_front());
         if (m_out && rv) begin
            m_out = 0;
            if (m_drop) m_drop = 0;
            else begin
               n.instr = word_at(m_pc);
               n.pc    = m_pc;
               q.push_back(n);
               m_pc    = m_pc + 32'd4;
               m_clean = 0;
            end
         end
         if (er && g) begin m_out = 1; m_drop = 0; end
      end
      if (r) mem_pend = 0;
      else begin
         if (rv) mem_pend = 0;
         if (imem_req && g) begin
            mem_pend = 1; mem_addr = imem_addr; mem_cnt = l - 1;
         end else if (mem_pend && mem_cnt > 0) mem_cnt--;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] held_instr;
   logic [31:0] held_pc;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      step(1, 0, 0, 0, 0, 1);

      // First request in the first cycle out of reset; back-to-back traffic
      rst = 0; imem_gnt = 1;
      #1;
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      chk("c2_valid", {31'h0, if_valid}, 32'h1);
      chk("c2_rs", {27'h0, rs}, 32'd9);
      chk("c2_rt", {27'h0, rt}, 32'd10);
      chk("c2_rd", {27'h0, rd}, 32'd8);
      chk("c2_addr", imem_addr, 32'h4);
      chk("c2_req", {31'h0, imem_req}, 32'h1);
      repeat (6) step(0, 0, 1, 0, 0, 1);

      // Stall 3 cycles with the slot full while a response arrives
      held_instr = if_instr;
      held_pc    = if_pc;
      repeat (3) step(0, 1, 1, 0, 0, 1);
      chk("stall_hold_instr", if_instr, held_instr);
      chk("stall_hold_pc", if_pc, held_pc);
      chk("hold_no_req", {31'h0, imem_req}, 32'h0);
      step(0, 0, 1, 0, 0, 1);
      chk("skid_pc", if_pc, held_pc + 32'd4);
      chk("skid_instr", if_instr, word_at(held_pc + 32'd4));
      repeat (4) step(0, 0, 1, 0, 0, 1);

      // Redirect coincident with the grant for 0x8
      step(1, 0, 0, 0, 0, 1);
      repeat (4) step(0, 0, 1, 0, 0, 1);
      chk("pre_redirect_addr", imem_addr, 32'h8);
      step(0, 0, 1, 1, 32'h0000_0100, 2);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_req", {31'h0, imem_req}, 32'h1);
      chk("redir_valid", {31'h0, if_valid}, 32'h0);

      // Redirect coincident with rvalid in WAIT, under stall
      step(0, 0, 1, 0, 0, 1);
      step(0, 1, 0, 1, 32'h0000_0200, 1);
      chk("redir_rv_addr", imem_addr, 32'h200);
      chk("redir_rv_valid", {31'h0, if_valid}, 32'h0);

      // PC wrap; low redirect bits ignored
      step(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
      chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

      // Reset asserted while waiting for a response
      step(0, 0, 1, 0, 0, 3);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      chk("rst_wait_req", {31'h0, imem_req}, 32'h0);
      chk("rst_wait_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_wait_instr", if_instr, 32'h0);
      chk("rst_wait_pc", if_pc, 32'h0);
      step(1, 0, 0, 0, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 70,
              $urandom_range(0, 99) < 6,
              $urandom,
              $urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
